// File: rtl/keyboard_event_queue_if.sv
// Instruction, key-event and register-file write bundle
// for the keyboard event queue.
interface keyboard_event_queue_if #(
   parameter int unsigned KEY_W = 8
);
   logic [31:0]      inst;
   logic             inst_valid;
   logic             key_valid;
   logic             key_break;
   logic [KEY_W-1:0] keycode;
   logic             enable;
   logic             float;
   logic [4:0]       addr;
   logic [31:0]      data;

   modport master (
      output inst, inst_valid,
      output key_valid, key_break, keycode,
      input  enable, float, addr, data
   );

   modport slave (
      input  inst, inst_valid,
      input  key_valid, key_break, keycode,
      output enable, float, addr, data
   );
endinterface

// File: rtl/keyboard_event_queue.sv
// Buffered PS/2 key event queue with READKEY/PEEKKEY/KEYCNT
// decode and one registered integer register-file write.
module keyboard_event_queue #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned KEY_W      = 8,
   parameter bit          DROP_BREAK = 1'b0,
   parameter logic [5:0]  READKEY    = 6'b001001,
   parameter logic [5:0]  PEEKKEY    = 6'b001010,
   parameter logic [5:0]  KEYCNT     = 6'b001011,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = PW + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   keyboard_event_queue_if.slave  bus,
   output logic [CW-1:0]          count,
   output logic                   overflow
);

   typedef logic [KEY_W:0] entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [5:0]      op;
   logic            dec_read;
   logic            dec_peek;
   logic            dec_cnt;
   logic            dec_any;
   logic            empty;
   logic            full;
   logic            push_req;
   logic            push;
   logic            pop;
   logic            drop;
   entry_t          head;
   logic [31:0]     head_word;
   logic [31:0]     cnt_word;
   logic [31:0]     wdata;
   logic            enable_q;
   logic [4:0]      addr_q;
   logic [31:0]     data_q;

   assign op       = bus.inst[31:26];
   assign dec_read = bus.inst_valid && (op == READKEY);
   assign dec_peek = bus.inst_valid && (op == PEEKKEY);
   assign dec_cnt  = bus.inst_valid && (op == KEYCNT);
   assign dec_any  = dec_read || dec_peek || dec_cnt;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A full queue still takes a push when READKEY frees the head slot
   assign pop      = dec_read && !empty;
   assign push_req = bus.key_valid && !(DROP_BREAK && bus.key_break);
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && !push;

   assign head      = mem[rd_ptr];
   assign head_word = empty ? 32'h0 : 32'({1'b1, head});
   assign cnt_word  = {overflow, {(31-CW){1'b0}}, count};

   always_comb begin
      wdata = 32'h0;
      unique case (1'b1)
         dec_cnt:  wdata = cnt_word;
         dec_read: wdata = head_word;
         dec_peek: wdata = head_word;
         default:  wdata = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[wr_ptr] <= {bus.key_break, bus.keycode};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         enable_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
         // A drop in the same cycle as KEYCNT keeps the flag set
         if (drop) begin
            overflow <= 1'b1;
         end else if (dec_cnt) begin
            overflow <= 1'b0;
         end
         enable_q <= dec_any;
         if (dec_any) begin
            addr_q <= bus.inst[20:16];
            data_q <= wdata;
         end
      end
   end

   assign bus.enable = enable_q;
   assign bus.float  = 1'b0;
   assign bus.addr   = addr_q;
   assign bus.data   = data_q;

endmodule

// File: tb/tb_keyboard_event_queue.sv
// Directed bench for keyboard_event_queue: FIFO order,
// empty reads, overflow, full push+pop wrap, break drop, reset.
module tb_keyboard_event_queue;

   localparam logic [5:0] OP_READ = 6'b001001;
   localparam logic [5:0] OP_PEEK = 6'b001010;
   localparam logic [5:0] OP_CNT  = 6'b001011;
   localparam logic [5:0] OP_NONE = 6'b000000;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] count_a;
   logic       overflow_a;
   logic [4:0] count_b;
   logic       overflow_b;

   int vectors = 0;
   int miscompares = 0;

   keyboard_event_queue_if #(.KEY_W(8)) bus_a ();
   keyboard_event_queue_if #(.KEY_W(8)) bus_b ();

   keyboard_event_queue #(.DEPTH(16), .KEY_W(8), .DROP_BREAK(1'b0)) dut_a (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_a.slave),
      .count    (count_a),
      .overflow (overflow_a)
   );

   keyboard_event_queue #(.DEPTH(16), .KEY_W(8), .DROP_BREAK(1'b1)) dut_b (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_b.slave),
      .count    (count_b),
      .overflow (overflow_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus to queue A, then sample 1 ns after the edge
   task automatic cyc(input logic [5:0] op, input logic [4:0] rt,
                      input logic iv, input logic kv,
                      input logic kb, input logic [7:0] kc);
      bus_a.inst       = {op, 5'd0, rt, 16'h0};
      bus_a.inst_valid = iv;
      bus_a.key_valid  = kv;
      bus_a.key_break  = kb;
      bus_a.keycode    = kc;
      @(posedge clk);
      #1;
      bus_a.inst_valid = 1'b0;
      bus_a.key_valid  = 1'b0;
   endtask

   task automatic push(input logic [7:0] kc);
      cyc(OP_NONE, 5'd0, 1'b0, 1'b1, 1'b0, kc);
   endtask

   task automatic instr(input logic [5:0] op, input logic [4:0] rt);
      cyc(op, rt, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic idle();
      cyc(OP_NONE, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      idle();
      reset = 1'b0;
   endtask

   initial begin
      bus_a.inst = '0;
      bus_a.inst_valid = 1'b0;
      bus_a.key_valid = 1'b0;
      bus_a.key_break = 1'b0;
      bus_a.keycode = '0;
      bus_b.inst = '0;
      bus_b.inst_valid = 1'b0;
      bus_b.key_valid = 1'b0;
      bus_b.key_break = 1'b0;
      bus_b.keycode = '0;
      reset = 1'b1;

      // reset state
      do_reset();
      check("rst_enable", 32'(bus_a.enable), 32'd0);
      check("rst_addr", 32'(bus_a.addr), 32'd0);
      check("rst_data", bus_a.data, 32'h0);
      check("rst_count", 32'(count_a), 32'd0);
      check("rst_ovf", 32'(overflow_a), 32'd0);
      check("float", 32'(bus_a.float), 32'd0);

      // two pushes, two READKEYs in order
      push(8'h1C);
      push(8'h32);
      check("t1_count2", 32'(count_a), 32'd2);
      instr(OP_READ, 5'd5);
      check("t1_en1", 32'(bus_a.enable), 32'd1);
      check("t1_addr1", 32'(bus_a.addr), 32'd5);
      check("t1_data1", bus_a.data, 32'h21C);
      check("t1_count1", 32'(count_a), 32'd1);
      instr(OP_READ, 5'd5);
      check("t1_data2", bus_a.data, 32'h232);
      check("t1_count0", 32'(count_a), 32'd0);
      idle();
      check("t1_en_off", 32'(bus_a.enable), 32'd0);

      // empty READKEY, then empty READKEY with concurrent push
      instr(OP_READ, 5'd3);
      check("t2_en", 32'(bus_a.enable), 32'd1);
      check("t2_addr", 32'(bus_a.addr), 32'd3);
      check("t2_data", bus_a.data, 32'h0);
      check("t2_count", 32'(count_a), 32'd0);
      cyc(OP_READ, 5'd4, 1'b1, 1'b1, 1'b0, 8'h44);
      check("t2_pushrd_data", bus_a.data, 32'h0);
      check("t2_pushrd_count", 32'(count_a), 32'd1);
      instr(OP_READ, 5'd4);
      check("t2_queued", bus_a.data, 32'h244);
      check("t2_count0", 32'(count_a), 32'd0);

      // fill past capacity
      for (int i = 0; i < 17; i++) begin
         push(8'(8'h10 + i));
      end
      check("t3_count", 32'(count_a), 32'd16);
      check("t3_ovf", 32'(overflow_a), 32'd1);
      instr(OP_CNT, 5'd7);
      check("t3_cnt_data", bus_a.data, 32'h8000_0010);
      check("t3_cnt_addr", 32'(bus_a.addr), 32'd7);
      check("t3_ovf_clr", 32'(overflow_a), 32'd0);
      check("t3_cnt_keep", 32'(count_a), 32'd16);

      // full queue: push accepted alongside READKEY, then drain with wrap
      cyc(OP_READ, 5'd1, 1'b1, 1'b1, 1'b0, 8'h5A);
      check("t4_data", bus_a.data, 32'h210);
      check("t4_count", 32'(count_a), 32'd16);
      check("t4_ovf", 32'(overflow_a), 32'd0);
      for (int i = 1; i < 16; i++) begin
         instr(OP_READ, 5'd1);
         check("t4_drain", bus_a.data, 32'h200 | 32'(8'h10 + i));
      end
      instr(OP_READ, 5'd1);
      check("t4_last", bus_a.data, 32'h25A);
      check("t4_empty", 32'(count_a), 32'd0);

      // break events: dropped by B, kept by A
      bus_b.key_valid = 1'b1;
      bus_b.key_break = 1'b1;
      bus_b.keycode   = 8'hF0;
      cyc(OP_NONE, 5'd0, 1'b0, 1'b1, 1'b1, 8'hF0);
      bus_b.key_valid = 1'b0;
      check("t5_drop_cnt", 32'(count_b), 32'd0);
      check("t5_drop_ovf", 32'(overflow_b), 32'd0);
      check("t5_keep_cnt", 32'(count_a), 32'd1);
      instr(OP_PEEK, 5'd9);
      check("t5_peek_data", bus_a.data, 32'h3F0);
      check("t5_peek_addr", 32'(bus_a.addr), 32'd9);
      check("t5_peek_cnt", 32'(count_a), 32'd1);
      instr(OP_PEEK, 5'd9);
      check("t5_peek2", bus_a.data, 32'h3F0);

      // reset beats an in-flight READKEY
      do_reset();
      push(8'h01);
      push(8'h02);
      push(8'h03);
      check("t6_pre_cnt", 32'(count_a), 32'd3);
      reset = 1'b1;
      instr(OP_READ, 5'd2);
      reset = 1'b0;
      check("t6_en", 32'(bus_a.enable), 32'd0);
      check("t6_cnt", 32'(count_a), 32'd0);
      check("t6_ovf", 32'(overflow_a), 32'd0);
      idle();
      check("t6_en_after", 32'(bus_a.enable), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
